// File: rtl/rotating_square_n_if.sv
// Control and display bundle for rotating_square_n.
// The revs counter port exists only when ROTSQ_REV_COUNT_EN is defined.
interface rotating_square_n_if #(
    parameter int NUM_DIGITS = 4,
    parameter int POS_W      = $clog2(2 * NUM_DIGITS)
);
    logic                  en;
    logic                  cw;
    logic                  mode;
    logic [1:0]            speed;
    logic [NUM_DIGITS-1:0] an;
    logic [7:0]            sseg;
    logic [POS_W-1:0]      pos;
    logic                  step;
`ifdef ROTSQ_REV_COUNT_EN
    logic [7:0]            revs;

    modport master (output en, cw, mode, speed, input an, sseg, pos, step, revs);
    modport slave  (input en, cw, mode, speed, output an, sseg, pos, step, revs);
`else
    modport master (output en, cw, mode, speed, input an, sseg, pos, step);
    modport slave  (input en, cw, mode, speed, output an, sseg, pos, step);
`endif
endinterface

// File: rtl/rotating_square_n.sv
// Walks one lit square segment around the perimeter of an N-digit display.
// Optional ROTSQ_REV_COUNT_EN adds an 8-bit wrap/reversal counter (revs).
//
// state | meaning
// UP    | position moves towards 2N-1 (ping-pong), or last loop step was cw
// DOWN  | position moves towards 0 (ping-pong), or last loop step was ccw
module rotating_square_n #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int POS_W      = $clog2(2 * NUM_DIGITS)
) (
    input logic clk,
    input logic rst,
    rotating_square_n_if.slave bus
);
    localparam int               CNT_W  = $clog2(TICK_DIV);
    localparam logic [POS_W-1:0] LAST   = POS_W'(2 * NUM_DIGITS - 1);
    localparam logic [7:0]       TOP    = 8'b10011100;
    localparam logic [7:0]       BOTTOM = 8'b10100011;

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    dir_t             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      term;
    logic             step_c;
    int               digit;
    logic             glyph_top;

    // A speed change that lands below the current count fires at once
    always_comb begin
        term   = (32'(TICK_DIV) >> bus.speed) - 32'd1;
        step_c = bus.en && (32'(cnt_q) >= term);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= UP;
            pos_q <= '0;
            cnt_q <= '0;
        end else begin
            dir_q <= dir_d;
            pos_q <= pos_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        dir_d = dir_q;
        pos_d = pos_q;
        cnt_d = cnt_q;
        if (step_c) begin
            cnt_d = '0;
            if (!bus.mode) begin
                dir_d = bus.cw ? UP : DOWN;
                if (bus.cw)
                    pos_d = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
                else
                    pos_d = (pos_q == '0) ? LAST : pos_q - POS_W'(1);
            end else begin
                case (dir_q)
                    UP: begin
                        if (pos_q == LAST) begin
                            dir_d = DOWN;
                            pos_d = LAST - POS_W'(1);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end
                    DOWN: begin
                        if (pos_q == '0) begin
                            dir_d = UP;
                            pos_d = POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                    default: dir_d = UP;
                endcase
            end
        end else if (bus.en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Top row runs left to right at p = 0 only; bottom row 1..N; top row back N+1..2N-1
    always_comb begin
        digit     = 0;
        glyph_top = 1'b1;
        if (pos_q == '0) begin
            digit = 0;
        end else if (int'(pos_q) <= NUM_DIGITS) begin
            digit     = int'(pos_q) - 1;
            glyph_top = 1'b0;
        end else begin
            digit = 2 * NUM_DIGITS - int'(pos_q);
        end
        for (int i = 0; i < NUM_DIGITS; i++)
            bus.an[i] = (i != digit);
        bus.sseg = glyph_top ? TOP : BOTTOM;
    end

    assign bus.pos  = pos_q;
    assign bus.step = step_c;

`ifdef ROTSQ_REV_COUNT_EN
    logic       wrap;
    logic [7:0] revs_q;

    always_comb begin
        if (!bus.mode)
            wrap = bus.cw ? (pos_q == LAST) : (pos_q == '0);
        else
            wrap = (dir_q == UP) ? (pos_q == LAST) : (pos_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            revs_q <= '0;
        else if (step_c && wrap)
            revs_q <= revs_q + 8'd1;
    end

    assign bus.revs = revs_q;
`endif
endmodule

// File: doc/rotating_square_n.md
Name: rotating_square_n

Overview:
- Parametrised successor to the 4-digit rotating-square driver.
- Walks a single lit segment (upper square or lower square) around the perimeter of an N-digit 7-segment display.
- Step timing comes from an internal synchronous prescaler with selectable speed; no derived clocks.
- Two motion modes: continuous loop (CW/CCW) and ping-pong. Sits between the system clock and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 4, number of digits; legal range 2..8.
- TICK_DIV, 50_000_000, clk cycles per step at speed 0; must be ≥ 16.
- POS_W, $clog2(2*NUM_DIGITS), position register width (derived; do not override).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  1 = prescaler runs and steps occur; 0 = frozen.
- cw  in  1  loop mode direction: 1 = increasing position, 0 = decreasing.
- mode  in  1  0 = loop, 1 = ping-pong.
- speed  in  2  step period = TICK_DIV >> speed cycles.
- an  out  NUM_DIGITS  anode enables, active-low, exactly one bit low.
- sseg  out  8  cathodes {dp,g..a}, active-low.
- pos  out  POS_W  current position 0..2*NUM_DIGITS-1.
- step  out  1  one-clk pulse on cycles where position advances.

Behaviour:
- Reset values:
  - pos = 0, dir = up, prescaler cnt = 0, step = 0.
  - an = all ones except bit0 = 0.
  - sseg = TOP.
- Glyph encodings (dp always off):
  - TOP = 8'b10011100.
  - BOTTOM = 8'b10100011.
- Prescaler:
  - term = (TICK_DIV >> speed) - 1.
  - step = en && (cnt >= term), combinational from registered state.
  - On an edge with step = 1: cnt ← 0. Else if en: cnt ← cnt + 1. Else cnt holds; it is not cleared.
  - Speed change mid-count where cnt ≥ new term: step fires immediately, then the new period applies.
- Position decode (combinational from pos; N = NUM_DIGITS):
  - p = 0: digit 0, TOP.
  - 1 ≤ p ≤ N: digit p-1, BOTTOM.
  - N+1 ≤ p ≤ 2N-1: digit 2N-p, TOP.
  - Example for N = 4: positions 0..7 → d0T, d0B, d1B, d2B, d3B, d3T, d2T, d1T.
- Loop mode (mode = 0), on step:
  - cw = 1: pos ← (pos == 2N-1) ? 0 : pos + 1.
  - cw = 0: pos ← (pos == 0) ? 2N-1 : pos - 1.
  - Wrap is explicit; 2N need not be a power of two.
  - dir ← cw on every loop-mode step.
- Ping-pong mode (mode = 1), on step; cw is ignored:
  - dir up and pos < 2N-1: pos + 1.
  - dir up and pos == 2N-1: dir ← down, pos ← 2N-2.
  - dir down and pos > 0: pos - 1.
  - dir down and pos == 0: dir ← up, pos ← 1.
  - The endpoint is never held for two steps.
- Control changes:
  - cw/mode changes affect only the next step; no glitch on an/sseg between steps.
  - Entering ping-pong keeps the current dir.
- rst mid-count or mid-sweep returns all state to reset values immediately, asynchronously.
- an/sseg change only on clk edges where step = 1.
- Latency: pos/an/sseg update on the edge that samples step = 1.

Optional Feature:
- Macro: ROTSQ_REV_COUNT_EN.
- Defined:
  - Adds port revs out 8, reset 0.
  - Loop mode: increments on every step that wraps pos (2N-1→0 or 0→2N-1).
  - Ping-pong mode: increments on every direction reversal.
  - Wraps 255 → 0.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- NUM_DIGITS = 4, TICK_DIV = 16, speed = 0, en = 1, cw = 1, mode = 0, release rst → step every 16 clks; pos 0,1,…,7,0; an/sseg follow d0T, d0B, d1B, d2B, d3B, d3T, d2T, d1T (an 1110 with sseg 10011100 at pos 0).
- Same bench with cw = 0 from reset → pos 0, 7, 6, …, 1, 0; first step gives an = 1101, sseg = 10011100.
- NUM_DIGITS = 3, mode = 1 → pos 0,1,2,3,4,5,4,3,2,1,0,1; with ROTSQ_REV_COUNT_EN, revs = 2 after 12 steps.
- speed = 3 → step period 2 clks. Then at cnt = 10 with speed = 0, switch to speed = 2 → step on the next cycle, then every 4 clks.
- en = 0 for 20 clks at cnt = 5 → no step and pos frozen; after re-enable, step occurs 11 clks later.
- Assert rst asynchronously mid-period at pos = 5 → pos = 0, an = 1110, sseg = 10011100, step = 0 before the next clk edge.
